// File: rtl/mac_drain_pkg.sv
// Shared types and helpers for the MAC drain stage: serializer states,
// saturation-counter width and the signed saturation helper.
package mac_drain_pkg;

    localparam int SAT_CNT_W = 16;
    localparam int SAT_IN_W  = 64;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    typedef struct packed {
        logic signed [SAT_IN_W-1:0] val;
        logic                       clip;
    } sat_res_t;

    // Clamp a wide signed value into the signed range of an ow-bit word.
    function automatic sat_res_t sat_fn(input logic signed [SAT_IN_W-1:0] value,
                                        input int ow);
        logic signed [SAT_IN_W-1:0] hi;
        logic signed [SAT_IN_W-1:0] lo;
        sat_res_t                   r;
        hi     = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo     = -hi - 64'sd1;
        r.val  = value;
        r.clip = 1'b0;
        if (value > hi) begin
            r.val  = hi;
            r.clip = 1'b1;
        end else if (value < lo) begin
            r.val  = lo;
            r.clip = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_drain_fifo.sv
// Two-entry FIFO of quantised POX-lane vectors with simultaneous push/pop.
// Latency: a pushed vector is visible at the head the cycle after the push.
// Backpressure: a push into a full FIFO is only taken together with a pop.
module mac_drain_fifo #(
    parameter int POX = 3,
    parameter int OW  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [OW-1:0] push_dat [POX],
    input  logic          pop,
    output logic [OW-1:0] head_dat [POX],
    output logic [1:0]    count
);

    logic [OW-1:0] mem [2][POX];
    logic          wr_ptr;
    logic          rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/mac_drain.sv
// MAC bank drain: capture lane results, bias/shift/ReLU/saturate, serialise lanes.
// Latency: strobe at t gives lane 0 valid at t+3 when idle; one lane per cycle.
// Backpressure: out_ready stalls the serializer; hold tells upstream to stop strobing.
module mac_drain
    import mac_drain_pkg::*;
#(
    parameter  int DW  = 32,
    parameter  int POX = 3,
    parameter  int OW  = 8,
    localparam int LW  = (POX > 1) ? $clog2(POX) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] result [POX],
    input  logic                 cnt_c  [POX],
    input  logic signed [DW-1:0] bias,
    input  logic [4:0]           shamt,
    input  logic                 relu_en,
    output logic                 hold,
    output logic [OW-1:0]        out_data,
    output logic [LW-1:0]        out_lane,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 ovf_err,
    output logic                 lane_err,
    output logic [SAT_CNT_W-1:0] sat_cnt
);

    localparam int CW = $clog2(POX + 1);

    logic                all_c;
    logic                any_c;
    logic                cap_vld;

    logic                s1_vld;
    logic signed [DW:0]  s1_sum [POX];
    logic [4:0]          s1_shamt;
    logic                s1_relu;

    logic [OW-1:0]       q_dat  [POX];
    logic [POX-1:0]      q_clip;
    logic [CW-1:0]       clip_n;

    logic                s2_vld;
    logic [OW-1:0]       s2_dat [POX];

    logic [OW-1:0]       head_dat [POX];
    logic [1:0]          fifo_cnt;
    logic                fifo_pop;
    logic [2:0]          credit_used;

    ser_state_t          state_q;
    ser_state_t          state_nxt;
    logic [LW-1:0]       lane_q;
    logic                last_lane;
    logic                fire;

    always_comb begin
        all_c = 1'b1;
        any_c = 1'b0;
        for (int i = 0; i < POX; i++) begin
            all_c &= cnt_c[i];
            any_c |= cnt_c[i];
        end
    end

    assign cap_vld = all_c && !hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld   <= 1'b0;
            ovf_err  <= 1'b0;
            lane_err <= 1'b0;
        end else begin
            s1_vld <= cap_vld;
            if (all_c && hold)    ovf_err  <= 1'b1;
            if (any_c && !all_c)  lane_err <= 1'b1;
        end
    end

    // One extra bit of headroom means the bias add can never wrap.
    always_ff @(posedge clk) begin
        if (cap_vld) begin
            for (int i = 0; i < POX; i++) begin
                s1_sum[i] <= {result[i][DW-1], result[i]} + {bias[DW-1], bias};
            end
            s1_shamt <= shamt;
            s1_relu  <= relu_en;
        end
    end

    for (genvar g = 0; g < POX; g++) begin : g_quant
        logic signed [DW:0] sh;
        logic signed [DW:0] rl;
        sat_res_t           sr;
        logic               unused_hi;

        assign sh        = s1_sum[g] >>> s1_shamt;
        assign rl        = (s1_relu && sh[DW]) ? '0 : sh;
        assign sr        = sat_fn({{(SAT_IN_W-DW-1){rl[DW]}}, rl}, OW);
        assign q_dat[g]  = sr.val[OW-1:0];
        assign q_clip[g] = sr.clip;
        assign unused_hi = ^sr.val[SAT_IN_W-1:OW];
    end

    assign clip_n = CW'($countones(q_clip));

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld  <= 1'b0;
            sat_cnt <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                logic [SAT_CNT_W:0] tmp;
                tmp     = {1'b0, sat_cnt} + (SAT_CNT_W+1)'(clip_n);
                sat_cnt <= tmp[SAT_CNT_W] ? '1 : tmp[SAT_CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (s1_vld) s2_dat <= q_dat;
    end

    mac_drain_fifo #(
        .POX (POX),
        .OW  (OW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (s2_vld),
        .push_dat (s2_dat),
        .pop      (fifo_pop),
        .head_dat (head_dat),
        .count    (fifo_cnt)
    );

    // Every vector in flight owns a FIFO slot, so two in flight exhaust the credits.
    assign credit_used = 3'(fifo_cnt) + 3'(s1_vld) + 3'(s2_vld);
    assign hold        = (credit_used >= 3'd2);

    assign last_lane = (lane_q == LW'(POX - 1));
    assign fire      = out_valid && out_ready;
    assign fifo_pop  = fire && last_lane;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (s2_vld || (fifo_cnt != 2'd0)) state_nxt = SEND;
            SEND:    if (fifo_pop && (fifo_cnt == 2'd1) && !s2_vld) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_lane  = '0;
        out_last  = 1'b0;
        if (state_q == SEND) begin
            out_valid = 1'b1;
            out_data  = head_dat[lane_q];
            out_lane  = lane_q;
            out_last  = last_lane;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q <= '0;
        end else if (fire) begin
            lane_q <= last_lane ? '0 : lane_q + 1'b1;
        end
    end

endmodule
